// File: rtl/top_k_stream_sorter.sv
// -----------------------------------------------------------------------------
// top_k_stream_sorter
//
// Streaming top-K selector. Elements arrive one per cycle on an AXI-Stream
// slave port; a sorted register array keeps the best k_eff values seen so far
// in the current frame. When the frame's TLAST beat is accepted, the final
// array, including that element, is packed into a single-beat result word on
// the master port. The array is cleared on the same edge, so the next frame
// can start on the very next cycle.
//
// Parameters
//   K_MAX    number of sorter slots (1 .. OUT_W/DATA_W)
//   DATA_W   element width in bits (multiple of 8)
//   OUT_W    result word width (multiple of DATA_W)
//   SIGNED   1 = two's-complement compare, 0 = unsigned compare
//   KEEP_MIN 0 = keep largest values, 1 = keep smallest values
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   cfg_k                 results wanted per frame, latched on the first beat
//   s_axis_*              element input stream (tvalid/tready/tdata/tlast)
//   m_axis_tvalid/tready  result handshake
//   m_axis_tdata          lane i holds rank i (rank 0 = best); unused lanes are 0
//   m_axis_tkeep          byte enables of the filled lanes
//   m_axis_tlast          constant 1; every result is a single-beat frame
//   m_axis_tuser          frame element count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module top_k_stream_sorter #(
    parameter int K_MAX    = 16,
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 512,
    parameter int SIGNED   = 0,
    parameter int KEEP_MIN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          cfg_k,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [OUT_W-1:0]    m_axis_tdata,
    output logic [OUT_W/8-1:0]  m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [15:0]         m_axis_tuser
);

    localparam int LANES  = OUT_W / DATA_W;
    localparam int LANE_B = DATA_W / 8;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int CNT_W  = 17;

    generate
        if (K_MAX < 1 || K_MAX * DATA_W > OUT_W || (DATA_W % 8) != 0 || (OUT_W % DATA_W) != 0) begin : g_bad_cfg
            $error("top_k_stream_sorter: illegal K_MAX/DATA_W/OUT_W combination");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   slot_val_q [K_MAX];
    logic [DATA_W-1:0]   slot_val_d [K_MAX];
    logic [K_MAX-1:0]    slot_vld_q, slot_vld_d;
    logic [KW-1:0]       k_eff_q, k_eff_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_vld_q, out_vld_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [OUT_W/8-1:0]  out_keep_q, out_keep_d;
    logic [15:0]         out_user_q, out_user_d;
    logic                rdy_en_q, rdy_en_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                in_fire;
    logic                out_fire;
    logic [KW-1:0]       k_cfg;
    logic [KW-1:0]       k_use;
    logic [K_MAX-1:0]    ge;
    logic [KW-1:0]       ins_pos;
    logic                do_ins;
    logic [DATA_W-1:0]   ins_val [K_MAX];
    logic [K_MAX-1:0]    ins_vld;
    logic [DATA_W-1:0]   fin_val [K_MAX];
    logic [K_MAX-1:0]    fin_vld;
    logic [CNT_W-1:0]    cnt_inc;
    logic [OUT_W-1:0]    pack_data;
    logic [OUT_W/8-1:0]  pack_keep;

    // a is better than or equal to b under the configured ordering.
    function automatic logic better_eq(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic a_lt_b;
        logic b_lt_a;
        if (SIGNED != 0) begin
            a_lt_b = $signed(a) < $signed(b);
            b_lt_a = $signed(b) < $signed(a);
        end else begin
            a_lt_b = a < b;
            b_lt_a = b < a;
        end
        return (KEEP_MIN != 0) ? !b_lt_a : !a_lt_b;
    endfunction

    // rdy_en_q holds the input closed until the first clock after reset release.
    assign s_axis_tready = rdy_en_q & (!out_vld_q | m_axis_tready);
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign out_fire      = out_vld_q & m_axis_tready;

    always_comb begin
        if (cfg_k == 5'd0) begin
            k_cfg = KW'(1);
        end else if (int'(cfg_k) > K_MAX) begin
            k_cfg = KW'(K_MAX);
        end else begin
            k_cfg = KW'(cfg_k);
        end
    end

    // The first beat of a frame uses the live cfg_k; later beats use the latched copy.
    assign k_use = (state_q == ST_IDLE) ? k_cfg : k_eff_q;

    // Valid slots form a sorted prefix, so the better-or-equal hits are a
    // prefix too and their population count is the insert position. Counting
    // equal slots as "ahead" places a tie after the earlier arrival.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K_MAX; i++) begin
            ins_pos = ins_pos + KW'(ge[i]);
        end
    end

    assign do_ins  = in_fire & (ins_pos < k_use);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < K_MAX; gi++) begin : g_slot
            assign ge[gi] = slot_vld_q[gi] & better_eq(slot_val_q[gi], s_axis_tdata);

            if (gi == 0) begin : g_head
                assign ins_val[gi] = (ins_pos == '0) ? s_axis_tdata : slot_val_q[gi];
                assign ins_vld[gi] = (ins_pos == '0) ? 1'b1 : slot_vld_q[gi];
            end else begin : g_body
                // Above the insert point slots keep their value; below it they
                // take their upper neighbour, pushing the worst one off the end.
                assign ins_val[gi] = (KW'(gi) < ins_pos)  ? slot_val_q[gi]   :
                                     (KW'(gi) == ins_pos) ? s_axis_tdata     :
                                                            slot_val_q[gi-1];
                // Slots at or beyond k_eff are never kept valid, so the valid
                // count is always min(k_eff, elements seen).
                assign ins_vld[gi] = (KW'(gi) < k_use) &
                                     ((KW'(gi) < ins_pos)  ? slot_vld_q[gi]   :
                                      (KW'(gi) == ins_pos) ? 1'b1             :
                                                             slot_vld_q[gi-1]);
            end

            assign fin_val[gi] = do_ins ? ins_val[gi] : slot_val_q[gi];
            assign fin_vld[gi] = do_ins ? ins_vld[gi] : slot_vld_q[gi];
        end

        // Output lanes come straight from the post-insert array so the TLAST
        // element is included in the result captured on the same edge.
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < K_MAX) begin : g_used
                assign pack_data[gi*DATA_W +: DATA_W] = fin_vld[gi] ? fin_val[gi] : '0;
                assign pack_keep[gi*LANE_B +: LANE_B] = {LANE_B{fin_vld[gi]}};
            end else begin : g_unused
                assign pack_data[gi*DATA_W +: DATA_W] = '0;
                assign pack_keep[gi*LANE_B +: LANE_B] = '0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slot_val_d = slot_val_q;
        slot_vld_d = slot_vld_q;
        k_eff_d    = k_eff_q;
        cnt_d      = cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_user_d = out_user_q;
        rdy_en_d   = 1'b1;

        if (out_fire) begin
            out_vld_d = 1'b0;
        end

        if (in_fire) begin
            if (state_q == ST_IDLE) begin
                k_eff_d = k_cfg;
            end
            if (s_axis_tlast) begin
                // Frame close wins over a same-cycle transfer: the output
                // register reloads and tvalid stays high.
                out_vld_d  = 1'b1;
                out_data_d = pack_data;
                out_keep_d = pack_keep;
                out_user_d = cnt_inc[CNT_W-1] ? 16'hFFFF : cnt_inc[15:0];
                slot_vld_d = '0;
                cnt_d      = '0;
                state_d    = ST_IDLE;
            end else begin
                slot_val_d = fin_val;
                slot_vld_d = fin_vld;
                cnt_d      = cnt_inc;
                state_d    = ST_ACCUM;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < K_MAX; i++) begin
                slot_val_q[i] <= '0;
            end
            slot_vld_q <= '0;
            k_eff_q    <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_user_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_val_q <= slot_val_d;
            slot_vld_q <= slot_vld_d;
            k_eff_q    <= k_eff_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_user_q <= out_user_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = 1'b1;

endmodule

// File: tb/tb_top_k_stream_sorter.sv
// -----------------------------------------------------------------------------
// tb_top_k_stream_sorter
//
// Two sorter instances share one input stream: A uses the default ordering
// (unsigned, keep largest), B is signed and keeps the smallest. Each accepted
// frame is run through a reference model that does a stable selection sort of
// the whole frame; the expected result words are queued and a negedge monitor
// pops and compares them as each DUT delivers results.
// -----------------------------------------------------------------------------
module tb_top_k_stream_sorter;

    localparam int K  = 16;
    localparam int DW = 32;
    localparam int OW = 512;
    localparam int KB = OW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]    cfg_k    = 5'd4;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tlast  = 1'b0;
    logic          m_tready;

    logic          a_sready, a_mvalid, a_mlast;
    logic [OW-1:0] a_mdata;
    logic [KB-1:0] a_mkeep;
    logic [15:0]   a_muser;
    logic          b_sready, b_mvalid, b_mlast;
    logic [OW-1:0] b_mdata;
    logic [KB-1:0] b_mkeep;
    logic [15:0]   b_muser;

    top_k_stream_sorter #(.K_MAX(K), .DATA_W(DW), .OUT_W(OW), .SIGNED(0), .KEEP_MIN(0)) dut_a (
        .clk(clk), .rst(rst), .cfg_k(cfg_k),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(a_sready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(a_mvalid), .m_axis_tready(m_tready), .m_axis_tdata(a_mdata),
        .m_axis_tkeep(a_mkeep), .m_axis_tlast(a_mlast), .m_axis_tuser(a_muser)
    );

    top_k_stream_sorter #(.K_MAX(K), .DATA_W(DW), .OUT_W(OW), .SIGNED(1), .KEEP_MIN(1)) dut_b (
        .clk(clk), .rst(rst), .cfg_k(cfg_k),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(b_sready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(b_mvalid), .m_axis_tready(m_tready), .m_axis_tdata(b_mdata),
        .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser)
    );

    typedef struct {
        logic [OW-1:0] d;
        logic [KB-1:0] k;
        logic [15:0]   u;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] cur_vals[$];
    int            cur_k = 1;
    int            total = 0;
    int            bad   = 0;
    int            tr_mode = 0;   // 0: tready high, 1: random, 2: held low
    bit            lat_pending = 0;
    int            cyc = 0;
    bit            hold_arm[2];
    logic [OW-1:0] hold_d[2];
    logic [KB-1:0] hold_k[2];
    logic [15:0]   hold_u[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit better(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn, input bit mn);
        longint va, vb;
        va = sgn ? longint'($signed(a)) : longint'(a);
        vb = sgn ? longint'($signed(b)) : longint'(b);
        return mn ? (va < vb) : (va > vb);
    endfunction

    // Stable selection: repeatedly take the best remaining value, earliest on ties.
    task automatic model_result(input bit sgn, input bit mn, output exp_t e);
        logic [DW-1:0] vals[$];
        int n;
        vals = cur_vals;
        n = (cur_k < vals.size()) ? cur_k : vals.size();
        e.d = '0;
        e.k = '0;
        for (int r = 0; r < n; r++) begin
            int bi;
            bi = 0;
            for (int j = 1; j < vals.size(); j++) begin
                if (better(vals[j], vals[bi], sgn, mn)) bi = j;
            end
            e.d[r*DW +: DW] = vals[bi];
            e.k[r*(DW/8) +: DW/8] = '1;
            vals.delete(bi);
        end
        e.u = (cur_vals.size() > 65535) ? 16'hFFFF : 16'(cur_vals.size());
    endtask

    task automatic model_accept(input logic [DW-1:0] v, input bit last, input logic [4:0] k);
        exp_t ea, eb;
        if (cur_vals.size() == 0) cur_k = (k == 5'd0) ? 1 : ((int'(k) > K) ? K : int'(k));
        cur_vals.push_back(v);
        if (last) begin
            model_result(1'b0, 1'b0, ea);
            model_result(1'b1, 1'b1, eb);
            qa.push_back(ea);
            qb.push_back(eb);
            cur_vals.delete();
            lat_pending = 1;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] v, input bit last, input logic [4:0] k, input int gap);
        bit acc;
        int tries;
        if (gap > 0) begin
            s_tvalid = 1'b0;
            repeat (gap) tick();
        end
        s_tvalid = 1'b1;
        s_tdata  = v;
        s_tlast  = last;
        cfg_k    = k;
        acc   = 0;
        tries = 0;
        while (!acc) begin
            @(negedge clk);
            acc = a_sready;
            tick();
            tries++;
            if (!acc && tries > 3000) begin
                chk(1'b0, "accept_timeout", OW'(tries), OW'(0));
                break;
            end
        end
        if (acc) model_accept(v, last, k);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        chk(qa.size() == 0 && qb.size() == 0, "drain", OW'(qa.size() + qb.size()), OW'(0));
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            tick();
            case (tr_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 9) < 7);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int id, input logic v, input logic [OW-1:0] d, input logic [KB-1:0] k,
                       input logic [15:0] u, input logic l);
        exp_t e;
        bit   have;
        if (hold_arm[id]) begin
            chk(v && d == hold_d[id] && k == hold_k[id] && u == hold_u[id],
                $sformatf("hold%0d", id), d, hold_d[id]);
        end
        hold_arm[id] = v && !m_tready;
        hold_d[id] = d;
        hold_k[id] = k;
        hold_u[id] = u;
        if (v && m_tready) begin
            have = (id == 0) ? (qa.size() != 0) : (qb.size() != 0);
            if (!have) begin
                chk(1'b0, $sformatf("unexpected%0d", id), d, OW'(0));
            end else begin
                if (id == 0) e = qa.pop_front();
                else         e = qb.pop_front();
                chk(d == e.d, $sformatf("data%0d", id), d, e.d);
                chk(k == e.k, $sformatf("keep%0d", id), OW'(k), OW'(e.k));
                chk(u == e.u, $sformatf("user%0d", id), OW'(u), OW'(e.u));
                chk(l == 1'b1, $sformatf("tlast%0d", id), OW'(l), OW'(1));
                $display("result dut%0d: user=%0d keep=%h lane0=%h", id, u, k, d[DW-1:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            hold_arm[0] = 0;
            hold_arm[1] = 0;
        end else begin
            if (lat_pending) begin
                chk(a_mvalid && b_mvalid, "latency", OW'({a_mvalid, b_mvalid}), OW'(3));
                lat_pending = 0;
            end
            mon(0, a_mvalid, a_mdata, a_mkeep, a_muser, a_mlast);
            mon(1, b_mvalid, b_mdata, b_mkeep, b_muser, b_mlast);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        logic [DW-1:0] v;

        // Reset values
        repeat (2) @(negedge clk);
        chk(!a_mvalid && !b_mvalid, "rst_tvalid", OW'({a_mvalid, b_mvalid}), OW'(0));
        chk(a_mdata == '0 && b_mdata == '0, "rst_tdata", a_mdata | b_mdata, OW'(0));
        chk(a_mkeep == '0 && a_muser == '0, "rst_keep_user", OW'({a_mkeep, a_muser}), OW'(0));
        tick();
        rst = 1'b1;
        tick();
        chk(a_sready && b_sready, "rst_sready", OW'({a_sready, b_sready}), OW'(3));

        // 1: cfg_k=4, 5,9,1,7,3
        send_beat(32'd5, 0, 5'd4, 0);
        send_beat(32'd9, 0, 5'd4, 0);
        send_beat(32'd1, 0, 5'd4, 0);
        send_beat(32'd7, 0, 5'd4, 0);
        send_beat(32'd3, 1, 5'd4, 0);
        idle(2);

        // 2: cfg_k=3, -2,5,-7,0
        send_beat(-32'sd2, 0, 5'd3, 0);
        send_beat(32'd5,   0, 5'd3, 0);
        send_beat(-32'sd7, 0, 5'd3, 0);
        send_beat(32'd0,   1, 5'd3, 0);
        idle(2);

        // 3: cfg_k=16, 4,4,2
        send_beat(32'd4, 0, 5'd16, 0);
        send_beat(32'd4, 0, 5'd16, 0);
        send_beat(32'd2, 1, 5'd16, 0);
        idle(2);
        drain();

        // 4: output blocked with one result pending
        tr_mode = 2;
        idle(2);
        send_beat(32'd11, 1, 5'd4, 0);
        fork
            begin
                send_beat(32'd21, 0, 5'd4, 0);
                send_beat(32'd22, 1, 5'd4, 0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk(!a_sready, "stall_ready", OW'(a_sready), OW'(0));
                end
                tr_mode = 0;
            end
        join
        idle(2);
        drain();

        // 5: back-to-back single-element frames
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send_beat($urandom, 1, 5'($urandom_range(0, 20)), 0);
        end
        chk(cyc - c0 == 10, "throughput", OW'(cyc - c0), OW'(10));
        idle(2);
        drain();

        // Random frames with random cfg_k per beat, gaps and backpressure
        tr_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 2))
                    0:       v = $urandom;
                    1:       v = 32'($urandom_range(0, 7));
                    default: v = 32'($urandom_range(0, 7)) - 32'd4;
                endcase
                send_beat(v, (b == len - 1), 5'($urandom_range(0, 20)),
                          ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end
        idle(2);
        tr_mode = 0;
        drain();

        // 6a: reset drops a held result
        tr_mode = 2;
        idle(2);
        send_beat(32'd77, 1, 5'd4, 0);
        idle(2);
        rst = 1'b0;
        qa.delete();
        qb.delete();
        cur_vals.delete();
        tr_mode = 0;
        idle(2);
        chk(!a_mvalid && a_mdata == '0, "rst_drop_held", a_mdata, OW'(0));
        rst = 1'b1;
        tick();

        // 6b: reset mid-frame, then a one-element frame
        send_beat(32'd100, 0, 5'd4, 0);
        send_beat(32'd200, 0, 5'd4, 0);
        send_beat(32'd300, 0, 5'd4, 0);
        s_tvalid = 1'b0;
        rst = 1'b0;
        cur_vals.delete();
        idle(2);
        rst = 1'b1;
        tick();
        send_beat(32'd8, 1, 5'd4, 0);
        idle(3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
